// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and round datapath.
package aes_pkg;

   typedef logic [0:127] state128_t;
   typedef logic [0:31]  word32_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } ks_state_t;

   localparam int AES_NR = 10;

   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational lookup. Shared by SubWord and SubBytes.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_key_schedule.sv
// On-the-fly AES-128 key expansion: emits round keys 0..10 over a valid/ready handshake.
// Optional key store for reverse replay is built when AES_KEY_STORE_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a cipher key, key_ready high
// S_RUN  | presenting round keys, advancing on each rk handshake
module aes128_key_schedule
   import aes_pkg::*;
#(
   parameter int NR = AES_NR   // only 10 is meaningful for AES-128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  state128_t   key_in,
   input  logic        key_valid,
   output logic        key_ready,
`ifdef AES_KEY_STORE_EN
   input  logic [3:0]  rd_idx,
   output state128_t   rd_key,
   output logic        store_full,
`endif
   output state128_t   rk_out,
   output logic [3:0]  rk_idx,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic        rk_last
);

   localparam logic [3:0] LAST_IDX = 4'(NR);

   ks_state_t  r_state;
   state128_t  r_rk;
   logic [3:0] r_idx;
   logic       r_valid;
   logic [7:0] r_rcon;

   word32_t    w_w0, w_w1, w_w2, w_w3;
   word32_t    w_rot, w_sub, w_t;
   word32_t    w_n0, w_n1, w_n2, w_n3;
   logic       w_hs;
   logic       w_at_last;

   assign w_w0 = r_rk[0:31];
   assign w_w1 = r_rk[32:63];
   assign w_w2 = r_rk[64:95];
   assign w_w3 = r_rk[96:127];

   // RotWord: byte 0 of w3 moves to the end.
   assign w_rot = {w_w3[8:31], w_w3[0:7]};

   for (genvar g = 0; g < 4; g++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[g*8 +: 8]),
         .o_byte (w_sub[g*8 +: 8])
      );
   end

   assign w_t  = w_sub ^ {r_rcon, 24'h000000};
   assign w_n0 = w_w0 ^ w_t;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;

   assign w_hs      = r_valid & rk_ready;
   assign w_at_last = (r_idx == LAST_IDX);

   // Sequencer: load the cipher key, then step the round key on every accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rk    <= '0;
         r_idx   <= 4'd0;
         r_valid <= 1'b0;
         r_rcon  <= RCON[0];
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (key_valid) begin
                  r_rk    <= key_in;
                  r_idx   <= 4'd0;
                  r_rcon  <= RCON[0];
                  r_valid <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_hs) begin
                  if (w_at_last) begin
                     r_valid <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_rk   <= {w_n0, w_n1, w_n2, w_n3};
                     r_idx  <= r_idx + 4'd1;
                     r_rcon <= xtime(r_rcon);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign key_ready = (r_state == S_IDLE);
   assign rk_out    = r_rk;
   assign rk_idx    = r_idx;
   assign rk_valid  = r_valid;
   assign rk_last   = r_valid & w_at_last;

`ifdef AES_KEY_STORE_EN
   state128_t  r_store [0:10];
   state128_t  r_rd_key;
   logic       r_store_full;

   // Capture every emitted round key at its round index; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         r_store[r_idx] <= r_rk;
      end
   end

   // Registered read port plus the full flag, set by the final handshake and cleared by a new key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_key     <= '0;
         r_store_full <= 1'b0;
      end else begin
         r_rd_key <= (rd_idx <= LAST_IDX) ? r_store[rd_idx] : '0;
         if (w_hs && w_at_last) begin
            r_store_full <= 1'b1;
         end else if (key_ready && key_valid) begin
            r_store_full <= 1'b0;
         end
      end
   end

   assign rd_key     = r_rd_key;
   assign store_full = r_store_full;
`endif

endmodule

// File: doc/aes128_key_schedule.md
Name: aes128_key_schedule

Overview:
- On-the-fly AES-128 key expansion. Accepts a 128-bit cipher key and emits round keys 0..10, one per accepted handshake.
- Sits directly upstream of the round datapath and drives its roundKey input.
- The round controller consumes one key per round and may stall the schedule with ready.
- Bit order is big-endian [0:127] throughout: bits [0:7] are byte 0, bits [0:31] are word w0.

Parameters:
- NR, 10, number of rounds after the initial AddRoundKey; the block emits NR+1 keys. Fixed at 10 for AES-128; any other value is illegal.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  [0:127]  cipher key.
- key_valid  input  1  key_in is valid.
- key_ready  output  1  block can accept a key (state IDLE).
- rk_out  output  [0:127]  current round key, registered.
- rk_idx  output  4  round number of rk_out, 0..10.
- rk_valid  output  1  rk_out is valid.
- rk_ready  input  1  consumer accepts rk_out.
- rk_last  output  1  rk_valid and rk_idx==10.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - rk_out=0, rk_idx=0, rk_valid=0, rcon=8'h01.
  - key_ready is combinational: high exactly when the state is IDLE.
- FSM states: IDLE and RUN.
- IDLE -> RUN on key_valid & key_ready (cycle N):
  - rk_out<=key_in, rk_idx<=0, rcon<=8'h01.
  - rk_valid=1 from cycle N+1. Latency from key acceptance to key 0 is 1 cycle.
- In RUN, on rk_valid & rk_ready:
  - If rk_idx==10: go to IDLE, rk_valid<=0. rk_out holds its last value.
  - Otherwise: rk_out<=next(rk_out), rk_idx<=rk_idx+1, rcon<=xtime(rcon).
  - With rk_ready held high, keys stream back-to-back; all 11 keys appear in 11 consecutive cycles.
- Stall: while rk_valid & !rk_ready, rk_out, rk_idx and rcon are held stable. Stalls of any length are legal.
- next() computation:
  - t = SubWord(RotWord(w3)) xor {rcon,24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord rotates bytes left by 1. SubWord applies the AES S-box to each of the 4 bytes.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - xtime = shift left 1, xor 8'h1B if the MSB was set.
- key_valid while in RUN: ignored. key_ready=0, so the handshake is not accepted and expansion continues undisturbed.
- A new key presented in the same cycle as the final (rk_idx==10) handshake is not accepted that cycle. It is accepted the following cycle, in IDLE.
- rst_n asserted mid-expansion: immediate return to reset values. The partially emitted sequence is abandoned; the consumer must discard it.
- The combinational path from next() to rk_out is registered. No combinational path exists from key_in to rk_out.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- Defined:
  - Adds an 11x128 key store written on every rk handshake, at the location given by rk_idx.
  - Adds ports rd_idx (input, 4) and rd_key (output, [0:127]). rd_key is registered and returns store[rd_idx] one cycle after rd_idx is presented.
  - Adds port store_full (output, 1): set on the rk_idx==10 handshake, cleared on the next key acceptance or on reset.
  - rd_idx>10 returns 0.
  - Lets the decryptor replay keys in reverse without re-expanding.
- Undefined: none of these ports or storage exist; behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg:
  - typedef state128_t = logic[0:127]; typedef word32_t = logic[0:31].
  - Constant AES_NR=10.
  - Rcon table as a constant array.
  - Function xtime.
- One sub-module: aes_sbox (8-bit combinational S-box, LUT).
  - Instantiated 4 times for SubWord.
  - Reused by the SubBytes stage.

Test Plan:
All keys below are from FIPS-197 A.1: key_in = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
- FIPS-197 A.1 streaming, rk_ready=1:
  - Key 0 = key_in at N+1.
  - Key 1 = a0fafe17 88542cb1 23a33939 2a6c7605 at N+2.
  - Key 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 at N+11, with rk_last=1.
  - key_ready=1 at N+12.
- Random rk_ready stalls (about 50%), same key:
  - All 11 keys identical to the streaming run.
  - rk_out and rk_idx stable during every stall cycle.
- key_valid held high with a second key during RUN:
  - Second key not accepted until IDLE.
  - First sequence completes correctly.
  - The second key is then expanded correctly.
- rst_n pulsed low at rk_idx=5:
  - All outputs return to reset values asynchronously.
  - A subsequent key expands correctly from index 0.
- AES_KEY_STORE_EN defined:
  - After a full expansion, rd_idx=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6 one cycle later.
  - rd_idx=0 gives key_in.
  - rd_idx=12 gives 0.
  - store_full=1, then clears on the next key acceptance.
